// File: rtl/mips_fetch_pkg.sv
// Shared constants and FSM encoding for the MIPS instruction fetch stage.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] PC_INCR = 32'd4;

    // Redirect targets are forced to word alignment.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble inserts a NOP, hold freezes, load captures the fetch.
module if_id_reg
    import mips_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic        hold,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc4_d,
    output logic [31:0] instr_q,
    output logic [31:0] pc4_q,
    output logic        valid_q
);

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            instr_q <= NOP;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (hold) begin
            instr_q <= instr_q;
            pc4_q   <= pc4_q;
            valid_q <= valid_q;
        end else if (load) begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, BOOT/RUN/HALTED sequencing and the IF/ID register.
//   state  | meaning
//   BOOT   | one cycle after reset, PC held, IF/ID bubbled
//   RUN    | normal fetch; halt > branch > stall/flush priority
//   HALTED | PC frozen, IF/ID bubbled, only reset leaves
module instruction_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc_nxt;
    logic [31:0]  pc_plus4;
    logic         run_live;
    logic         ifid_load;
    logic         ifid_hold;
    logic         ifid_bubble;

    assign pc_plus4  = pc + PC_INCR;
    assign imem_addr = {2'b00, pc[31:2]};
    assign run_live  = (state == RUN) && !halt && !branch_taken;

    assign ifid_load   = run_live && !stall && !flush;
    assign ifid_hold   = run_live && stall && !flush;
    assign ifid_bubble = !ifid_load && !ifid_hold;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (halt) begin
                    state_nxt = HALTED;
                end else if (branch_taken) begin
                    pc_nxt = word_align(branch_target);
                end else if (!stall) begin
                    pc_nxt = pc_plus4;
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (ifid_load),
        .bubble  (ifid_bubble),
        .hold    (ifid_hold),
        .instr_d (imem_instr),
        .pc4_d   (pc_plus4),
        .instr_q (if_id_instr),
        .pc4_q   (if_id_pc4),
        .valid_q (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized bench for instruction_fetch against a behavioural fetch model.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, flush, branch_taken, halt;
    logic [31:0] branch_target, imem_instr, imem_addr, pc;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid;

    int n_checks = 0;
    int n_errors = 0;

    // model: mode 0 = boot, 1 = running, 2 = halted
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] widx);
        return (widx * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {widx[15:0], 16'h1234};
    endfunction

    assign imem_instr = mem_word(imem_addr);

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .imem_instr    (imem_instr),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clock(input logic r, input logic st, input logic fl,
                               input logic br, input logic [31:0] tgt, input logic hl);
        if (r) begin
            m_pc = RST_PC; m_mode = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (m_mode == 0) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0; m_mode = 1;
        end else if (m_mode == 2) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (hl) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0; m_mode = 2;
        end else if (br) begin
            m_pc = (tgt / 4) * 4;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (st) begin
            if (fl) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end
        end else if (fl) begin
            m_pc = m_pc + 4;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else begin
            m_instr = mem_word(m_pc / 4);
            m_pc4   = m_pc + 4;
            m_valid = 1;
            m_pc    = m_pc + 4;
        end
    endtask

    task automatic check_all();
        check("pc",        pc,                  m_pc);
        check("imem_addr", imem_addr,           m_pc / 4);
        check("instr",     if_id_instr,         m_instr);
        check("pc4",       if_id_pc4,           m_pc4);
        check("valid",     {31'b0, if_id_valid}, {31'b0, m_valid});
    endtask

    task automatic step(input logic r, input logic st, input logic fl,
                        input logic br, input logic [31:0] tgt, input logic hl);
        reset = r; stall = st; flush = fl; branch_taken = br; branch_target = tgt; halt = hl;
        @(posedge clk);
        model_clock(r, st, fl, br, tgt, hl);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        logic [31:0] held_instr;
        reset = 1; stall = 0; flush = 0; branch_taken = 0; branch_target = 0; halt = 0;
        m_mode = 0; m_pc = RST_PC; m_instr = 0; m_pc4 = 0; m_valid = 0;
        @(negedge clk);

        // reset, boot and sequential fetch
        step(1, 0, 0, 0, 32'h0, 0);
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, if_id_valid}, 32'h0);
        idle();
        check("boot_valid", {31'b0, if_id_valid}, 32'h0);
        check("boot_addr", imem_addr, 32'd0);
        idle();
        check("run_addr1", imem_addr, 32'd1);
        check("run_pc4_4", if_id_pc4, 32'd4);
        idle();
        check("run_addr2", imem_addr, 32'd2);
        check("run_pc4_8", if_id_pc4, 32'd8);
        idle();
        check("run_addr3", imem_addr, 32'd3);
        check("run_pc4_12", if_id_pc4, 32'd12);

        // stall at pc=12 for three cycles, then stall+flush
        held_instr = if_id_instr;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 32'h0, 0);
            check("stall_pc", pc, 32'd12);
            check("stall_instr", if_id_instr, held_instr);
            check("stall_pc4", if_id_pc4, 32'd12);
        end
        step(0, 1, 1, 0, 32'h0, 0);
        check("stfl_pc", pc, 32'd12);
        check("stfl_valid", {31'b0, if_id_valid}, 32'h0);
        idle();

        // branch at pc=8
        step(1, 0, 0, 0, 32'h0, 0);
        idle(); idle(); idle();
        check("pre_br_pc", pc, 32'd8);
        step(0, 0, 1, 1, 32'h40, 0);
        check("br_pc", pc, 32'h40);
        check("br_addr", imem_addr, 32'd16);
        check("br_valid", {31'b0, if_id_valid}, 32'h0);
        idle();
        check("br_instr", if_id_instr, mem_word(32'd16));
        check("br_pc4", if_id_pc4, 32'h44);

        // misaligned target, then wrap
        step(0, 1, 0, 1, 32'h43, 0);
        check("align_pc", pc, 32'h40);
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        idle();
        check("wrap_pc", pc, 32'h0);
        check("wrap_pc4", if_id_pc4, 32'h0);

        // halt with branch, ignored pulses, reset recovery
        idle();
        step(0, 0, 0, 1, 32'h80, 1);
        check("halt_pc", pc, 32'h4);
        for (int i = 0; i < 4; i++) begin
            step(0, i[0], i[1], 1, 32'h100 + i * 4, 0);
            check("halted_pc", pc, 32'h4);
        end
        step(1, 0, 0, 1, 32'h200, 1);
        check("rst2_pc", pc, RST_PC);
        idle();
        check("boot2_pc", pc, RST_PC);
        idle();
        check("run2_pc", pc, RST_PC + 4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(5) == 0), ($urandom_range(5) == 0),
                 (($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(15) : $urandom),
                 ($urandom_range(47) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
